data_stack: RTL
===============

# data_stack

Parameter stack for the Forth core, holding the top-of-stack register T and the next-on-stack N. T and N drive the ALU operand buses, so N is the ALU's Y operand. The stack takes the ALU result back into T on arithmetic ops and pushes, drops and permutes entries under control of the instruction decoder. The ALU is combinational: the stack presents operands, and the ALU result is written back on the next rising edge.

## Interface
- WIDTH, 16, data width; matches ALU operand width
- DEPTH, 16, maximum number of stack items including T; must be ≥ 3
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- op  input  3  stack operation for this cycle (encodings under Operation)
- din  input  WIDTH  literal/memory data for PUSH
- alu_res  input  WIDTH  ALU Result output
- alu_c  input  1  ALU carry flag
- alu_z  input  1  ALU zero flag
- clr_err  input  1  clears sticky ovf/unf
- tos  output  WIDTH  T register; drives ALU operand 1
- nos  output  WIDTH  N (second item); drives ALU Y bus; 0 when depth < 2
- depth  output  $clog2(DEPTH+1)  number of valid items, 0..DEPTH
- empty  output  1  depth == 0
- full  output  1  depth == DEPTH
- ovf  output  1  sticky overflow error
- unf  output  1  sticky underflow error
- flag_c  output  1  registered ALU carry from last UNARY/BINARY
- flag_z  output  1  registered ALU zero from last UNARY/BINARY

One clock; reset is asynchronous and active-low.

## Operation
- **Storage**
  - T is a register.
  - Items below T live in array mem[0..DEPTH-2], where mem[d-2] is N for depth d.
  - nos is a combinational read of mem[depth-2], forced to 0 when depth < 2.
- **Op encodings and required depth.** An illegal op is suppressed entirely: T, mem and depth are unchanged, and the error is flagged.
  - 000 NOP: nothing.
  - 001 PUSH: needs d < DEPTH, else ovf. Writes mem[d-1] ← T (only if d ≥ 1), then T ← din, d+1.
  - 010 DROP: needs d ≥ 1, else unf. Sets T ← N (0 if d == 1), then d-1.
  - 011 UNARY: needs d ≥ 1, else unf. Sets T ← alu_res and captures flag_c/flag_z; d is unchanged.
  - 100 BINARY: needs d ≥ 2, else unf. Sets T ← alu_res and captures flags, then d-1; N is consumed.
  - 101 DUP: needs 1 ≤ d < DEPTH, with unf if d == 0 and ovf if full. Writes mem[d-1] ← T, then d+1.
  - 110 SWAP: needs d ≥ 2, else unf. Sets T ← N and mem[d-2] ← T.
  - 111 OVER: needs 2 ≤ d < DEPTH, with unf if d < 2 and ovf if full. Writes mem[d-1] ← T, sets T ← N, then d+1.
- **Flags**
  - flag_c and flag_z update only on a legal UNARY or BINARY; otherwise they hold.
- **Errors**
  - ovf and unf are set on the illegal op and stay set.
  - clr_err clears both.
  - If clr_err coincides with a new error, the new error wins and that flag is set.
  - The other flag is cleared in that case.
- **Arithmetic**
  - No width conversion; all data is WIDTH bits.
  - depth never wraps; saturation is enforced by the suppression rule above.

## Timing
- Reset values:
  - tos = 0, depth = 0.
  - ovf = unf = flag_c = flag_z = 0.
  - nos = 0, since depth < 2.
  - empty = 1, full = 0.
  - mem is not reset.
- op is sampled on the rising clk edge, and results are visible on outputs after that edge (1-cycle latency). The ALU sees the new tos/nos in the same cycle.
- The ALU path is combinational within one cycle: alu_res is computed from the current tos/nos and funct, and written back at the edge.
- Back-to-back ops are allowed every cycle with no stall.
- empty, full and nos are combinational from registered state.
- Reset asserted mid-sequence returns all outputs to their reset values immediately (asynchronous), regardless of op.

## Test plan
- **Reset and basic push/drop.** Reset, then PUSH 0x1111, PUSH 0x2222.
  - Required: tos = 0x2222, nos = 0x1111, depth = 2.
  - Then DROP. Required: tos = 0x1111, nos = 0, depth = 1, empty = 0.
- **Binary op.** With stack [0x0005, 0x0003] (T = 3), issue BINARY with alu_res = 0x0008, alu_z = 0.
  - Required: tos = 8, depth = 1, flag_z = 0.
  - Then UNARY with alu_res = 0, alu_z = 1. Required: tos = 0, flag_z = 1, depth = 1.
- **Permutations.** With stack [0xA, 0xB] (T = 0xB):
  - SWAP gives T = 0xA, N = 0xB.
  - OVER gives T = 0xB, N = 0xA, depth = 3.
  - DUP gives T = 0xB, N = 0xB, depth = 4.
- **Overflow (DEPTH = 4).** Fill to depth 4 with 1, 2, 3, 4, then PUSH 0x9.
  - Required: ovf = 1, tos = 4, depth = 4, full = 1.
  - Then DUP. Required: still suppressed, ovf stays 1.
- **Underflow and clear.** From reset, DROP.
  - Required: unf = 1, depth = 0, tos = 0.
  - Then pulse clr_err. Required: unf = 0.
  - Then BINARY at depth 1. Required: unf = 1, tos unchanged.
  - Then clr_err together with DROP at depth 0. Required: unf = 1.
- **Async reset mid-op.** At depth 3, assert reset_n low between clock edges.
  - Required: tos = 0, depth = 0, flags 0 immediately.
  - After release, PUSH 0x7. Required: tos = 7, depth = 1.

Source files
------------

// File: rtl/data_stack.sv
// Forth parameter stack: T in a register, the rest in a small array below it.
// One operation per clock; illegal ops are suppressed and raise sticky ovf/unf.
module data_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           din,
  input  logic [WIDTH-1:0]           alu_res,
  input  logic                       alu_c,
  input  logic                       alu_z,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           tos,
  output logic [WIDTH-1:0]           nos,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf,
  output logic                       flag_c,
  output logic                       flag_z
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH-1);

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_PUSH   = 3'b001,
    OP_DROP   = 3'b010,
    OP_UNARY  = 3'b011,
    OP_BINARY = 3'b100,
    OP_DUP    = 3'b101,
    OP_SWAP   = 3'b110,
    OP_OVER   = 3'b111
  } op_t;

  logic [WIDTH-1:0] mem [DEPTH-1];

  op_t              op_e;
  logic [AW-1:0]    idx_top;
  logic [AW-1:0]    idx_nos;
  logic             two_plus;
  logic [WIDTH-1:0] t_next;
  logic [DW-1:0]    d_next;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic             flag_we;
  logic             err_ovf;
  logic             err_unf;

  assign op_e     = op_t'(op);
  assign idx_top  = AW'(depth - DW'(1));
  assign idx_nos  = AW'(depth - DW'(2));
  assign two_plus = (depth >= DW'(2));
  assign empty    = (depth == '0);
  assign full     = (depth == DW'(DEPTH));
  assign nos      = two_plus ? mem[idx_nos] : '0;

  // Every op writes at most one array slot, and the value written is always the old T.
  always_comb begin
    t_next   = tos;
    d_next   = depth;
    mem_we   = 1'b0;
    mem_addr = idx_top;
    flag_we  = 1'b0;
    err_ovf  = 1'b0;
    err_unf  = 1'b0;
    case (op_e)
      OP_PUSH: begin
        if (full) err_ovf = 1'b1;
        else begin
          mem_we = !empty;
          t_next = din;
          d_next = depth + DW'(1);
        end
      end
      OP_DROP: begin
        if (empty) err_unf = 1'b1;
        else begin
          t_next = nos;
          d_next = depth - DW'(1);
        end
      end
      OP_UNARY: begin
        if (empty) err_unf = 1'b1;
        else begin
          t_next  = alu_res;
          flag_we = 1'b1;
        end
      end
      OP_BINARY: begin
        if (!two_plus) err_unf = 1'b1;
        else begin
          t_next  = alu_res;
          flag_we = 1'b1;
          d_next  = depth - DW'(1);
        end
      end
      OP_DUP: begin
        if (empty) err_unf = 1'b1;
        else if (full) err_ovf = 1'b1;
        else begin
          mem_we = 1'b1;
          d_next = depth + DW'(1);
        end
      end
      OP_SWAP: begin
        if (!two_plus) err_unf = 1'b1;
        else begin
          mem_we   = 1'b1;
          mem_addr = idx_nos;
          t_next   = nos;
        end
      end
      OP_OVER: begin
        if (!two_plus) err_unf = 1'b1;
        else if (full) err_ovf = 1'b1;
        else begin
          mem_we = 1'b1;
          t_next = nos;
          d_next = depth + DW'(1);
        end
      end
      default: ;
    endcase
  end

  // A fresh error beats clr_err; clr_err alone drops both sticky bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tos    <= '0;
      depth  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      tos   <= t_next;
      depth <= d_next;
      if (flag_we) begin
        flag_c <= alu_c;
        flag_z <= alu_z;
      end
      if (clr_err) begin
        ovf <= err_ovf;
        unf <= err_unf;
      end else begin
        ovf <= ovf | err_ovf;
        unf <= unf | err_unf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= tos;
  end

endmodule
